demo_scene_sequencer: RTL

- Frame-synchronous scheduler for the layered demo compositor (stars, rasterbars, text, sinescroll).
- Steps through a fixed table of scenes. Each scene enables a subset of layers and is faded in, held and faded out over whole frames.
- Drives per-layer enables and a master fade level that the compositor applies as `colour*fade_level>>8`.
- Supports a host skip request via a req/ack handshake, and a run/pause control.

---
 rtl/demo_seq_pkg.sv | 32 +++
 rtl/demo_fade_step.sv | 31 +++
 rtl/demo_scene_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/demo_seq_pkg.sv
// Shared types, constants and scene table for the demo scene sequencer.
package demo_seq_pkg;

  localparam int unsigned NUM_LAYERS = 4;
  localparam int unsigned NUM_SCENES = 4;
  localparam int unsigned FADE_BITS  = 8;
  localparam int unsigned DUR_BITS   = 12;
  localparam int unsigned IDX_BITS   = $clog2(NUM_SCENES);

  localparam logic [FADE_BITS-1:0] FADE_MAX = '1;

  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_t;

  typedef struct packed {
    logic [NUM_LAYERS-1:0] mask;
    logic [FADE_BITS-1:0]  step;
    logic [DUR_BITS-1:0]   hold;
  } scene_t;

  localparam scene_t SCENE_TABLE [NUM_SCENES] = '{
    '{mask: 4'b1111, step: 8'd64,  hold: 12'd2},
    '{mask: 4'b1001, step: 8'd0,   hold: 12'd0},
    '{mask: 4'b0011, step: 8'd128, hold: 12'd5},
    '{mask: 4'b0101, step: 8'd255, hold: 12'd1}
  };

  // A zero step means an instant cut to full or black.
  function automatic logic [FADE_BITS-1:0] eff_step(input logic [FADE_BITS-1:0] step);
    return (step == '0) ? FADE_MAX : step;
  endfunction

endpackage

// File: rtl/demo_fade_step.sv
// Combinational saturating add/subtract of the fade level by one step.
module demo_fade_step
  import demo_seq_pkg::*;
(
  input  logic [FADE_BITS-1:0] level_i,
  input  logic [FADE_BITS-1:0] step_i,
  input  logic                 up_i,
  output logic [FADE_BITS-1:0] level_o,
  output logic                 at_limit_o
);

  logic [FADE_BITS:0] sum;
  logic [FADE_BITS:0] diff;

  assign sum  = {1'b0, level_i} + {1'b0, step_i};
  assign diff = {1'b0, level_i} - {1'b0, step_i};

  always_comb begin
    level_o    = '0;
    at_limit_o = 1'b0;
    if (up_i) begin
      level_o    = sum[FADE_BITS] ? FADE_MAX : sum[FADE_BITS-1:0];
      at_limit_o = (level_o == FADE_MAX);
    end else begin
      // Borrow out of the top bit means the level would go below black.
      level_o    = diff[FADE_BITS] ? '0 : diff[FADE_BITS-1:0];
      at_limit_o = (level_o == '0);
    end
  end

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-synchronous scene scheduler: fades each table scene in, holds it, fades it out.
module demo_scene_sequencer
  import demo_seq_pkg::*;
(
  input  logic                  video_clk_pix,
  input  logic                  video_rst,
  input  logic                  frame_start,
  input  logic                  run,
  input  logic                  skip_req,
  output logic                  skip_ack,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [FADE_BITS-1:0]  fade_level,
  output logic [IDX_BITS-1:0]   scene_idx,
  output logic [1:0]            seq_state
);

  state_t                state_q;
  logic [FADE_BITS-1:0]  level_q;
  logic [NUM_LAYERS-1:0] mask_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [DUR_BITS-1:0]   hold_cnt_q;
  logic                  ack_q;

  scene_t                cur_scene;
  logic [IDX_BITS-1:0]   next_idx;
  logic                  fade_up;
  logic                  skip_now;
  logic [FADE_BITS-1:0]  fade_res;
  logic                  fade_at_limit;

  assign cur_scene = SCENE_TABLE[idx_q];
  assign next_idx  = (idx_q == IDX_BITS'(NUM_SCENES - 1)) ? '0 : idx_q + 1'b1;
  // Skip only cuts short a scene that is still rising or holding.
  assign skip_now  = skip_req && ((state_q == FADE_IN) || (state_q == HOLD));
  assign fade_up   = (state_q == IDLE) || ((state_q == FADE_IN) && !skip_req);

  demo_fade_step u_fade_step (
    .level_i    (level_q),
    .step_i     (eff_step(cur_scene.step)),
    .up_i       (fade_up),
    .level_o    (fade_res),
    .at_limit_o (fade_at_limit)
  );

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      state_q    <= IDLE;
      level_q    <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (frame_start && run) begin
        ack_q <= skip_req;
        unique case (state_q)
          IDLE: begin
            mask_q  <= SCENE_TABLE[0].mask;
            level_q <= fade_res;
            state_q <= FADE_IN;
          end
          FADE_IN: begin
            level_q <= fade_res;
            if (skip_now) begin
              state_q <= FADE_OUT;
            end else if (fade_at_limit) begin
              state_q    <= HOLD;
              hold_cnt_q <= '0;
            end
          end
          HOLD: begin
            if (skip_now || (hold_cnt_q == cur_scene.hold)) begin
              level_q <= fade_res;
              state_q <= FADE_OUT;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          FADE_OUT: begin
            level_q <= fade_res;
            // The mask only swaps on the frame the level reaches black.
            if (fade_at_limit) begin
              idx_q   <= next_idx;
              mask_q  <= SCENE_TABLE[next_idx].mask;
              state_q <= FADE_IN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign skip_ack   = ack_q;
  assign layer_en   = mask_q;
  assign fade_level = level_q;
  assign scene_idx  = idx_q;
  assign seq_state  = state_q;

endmodule
